rv32_mem_arbiter: RTL
=====================

Name: rv32_mem_arbiter

Overview:
Shares one memory port between the instruction-fetch requester and the memory-stage load/store requester. Grants the port to one requester at a time and holds the grant until the memory reports ready. Routes the response back to the granted requester. The other requester sees ready=0, which the pipeline treats as a stall. Sits between fetch/mem stages and the unified memory model.

Parameters:
MAX_DATA_BURST, 4, consecutive data-port completions allowed while a fetch is pending before fetch is forced to win (1..15)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
instr_request  in  memory_request_t  fetch request; uses fields valid, addr[31:0], wdata[31:0], we, wstrb[3:0]
instr_response  out  memory_response_t  fetch response; fields ready, data[31:0]
data_request  in  memory_request_t  load/store request from memory stage
data_response  out  memory_response_t  load/store response
mem_request  out  memory_request_t  request to shared memory
mem_response  in  memory_response_t  response from shared memory
grant_data  out  1  1 = data port currently owns memory (debug/observability)

Behaviour:
- Memory protocol:
  - Request is valid while .valid=1.
  - Completion is the cycle mem_response.ready=1; zero-wait memory may complete in the cycle of issue.
  - Requesters hold the request stable until their ready=1.
- FSM states IDLE, LOCK_I, LOCK_D. Reset state IDLE; starve_cnt=0.
- IDLE arbitration (combinational, this cycle):
  - Only one valid → grant it.
  - Both valid → data wins (older instruction), unless starve_cnt == MAX_DATA_BURST, in which case instr wins.
  - Neither valid → mem_request.valid=0; both ready=0; stay IDLE.
- Forwarding: mem_request = granted request. Granted response = mem_response. Non-granted response: ready=0, data=0.
- Transitions:
  - Granted and mem_response.ready=1 same cycle → stay IDLE.
  - Granted and not ready → LOCK_I or LOCK_D.
  - LOCK_x forwards only requester x regardless of the other port. On ready=1 → IDLE.
- Abort: if the locked requester drops valid, forward valid=0 and return to IDLE next cycle. No response is delivered.
- starve_cnt (4 bits, saturating at MAX_DATA_BURST) updates on each completion:
  - Data completion with instr valid pending → +1.
  - Instr completion → 0.
  - Any completion with instr not valid → 0.
- grant_data = 1 when the data port is forwarded this cycle (IDLE granting data, or LOCK_D).
- Reset asserted at any time, including mid-transaction:
  - State → IDLE, counters → 0.
  - mem_request.valid=0; both responses ready=0, data=0; grant_data=0.
  - The in-flight transaction is abandoned.
- No added latency: single-cycle combinational path from requester to memory and back. State is registered on clk.

Optional Feature:
RV32_ARB_PERF_EN
- With the macro defined: adds outputs perf_conflict_cycles and perf_data_stall_cycles (each CNT_W bits, reset 0, wrap-around on overflow).
  - perf_conflict_cycles increments every cycle both requests are valid.
  - perf_data_stall_cycles increments every cycle data_request.valid=1 and data_response.ready=0.
- Without it: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (rv32_types):
  - memory_request_t and memory_response_t (existing).
  - New enum arb_state_t {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D}.
  - Constant ARB_STARVE_W=4.
- Sub-module rv32_arb_select: pure combinational winner selection from (valid_i, valid_d, starve_cnt, MAX_DATA_BURST). The top module holds the FSM, counters and muxing.

Test Plan:
1. Both valid in IDLE, zero-wait memory, starve_cnt=0 → data granted, data_response.ready=1 same cycle, instr_response.ready=0, grant_data=1.
2. Instr alone, memory ready after 3 cycles; data asserts valid in cycle 1 → LOCK_I held; data ready=0 for cycles 0-2; instr ready=1 at cycle 2; data granted at cycle 3.
3. Both continuously valid, zero-wait, MAX_DATA_BURST=4 → grant pattern D,D,D,D,I repeats; starve_cnt sequence 1,2,3,4,0.
4. Reset pulsed during LOCK_D with memory not ready → immediately mem_request.valid=0 and both ready=0; after release the state is IDLE and a pending instr is granted first when data is not valid.
5. Data in LOCK_D drops valid before ready → mem_request.valid=0 that cycle; next cycle IDLE grants pending instr.
6. RV32_ARB_PERF_EN: 10 cycles both valid, memory 1-wait → perf_conflict_cycles=10; perf_data_stall_cycles equals the count of data-valid cycles with ready=0. The bench computes the expected value from the grant trace.

Source files
------------

// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared memory-port types plus arbiter state and starvation-counter width.
package rv32_types;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  wstrb;
  } memory_request_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } memory_response_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D} arb_state_t;

  localparam int ARB_STARVE_W = 4;

endpackage

// File: rtl/rv32_mem_arbiter_select.sv
// Combinational winner pick for an idle arbiter: data first unless fetch has starved too long.
module rv32_arb_select
  import rv32_types::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    valid_i,
  input  logic                    valid_d,
  input  logic [ARB_STARVE_W-1:0] starve_cnt,
  output logic                    grant_i,
  output logic                    grant_d
);

  localparam logic [ARB_STARVE_W-1:0] BURST_LIMIT = ARB_STARVE_W'(MAX_DATA_BURST);

  logic instr_forced;

  always_comb begin
    instr_forced = valid_i && (starve_cnt == BURST_LIMIT);
    grant_d      = valid_d && !instr_forced;
    grant_i      = valid_i && !grant_d;
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Fetch/load-store arbiter for one shared memory port; zero added latency, grant held until ready.
// Optional perf counters (conflict and data-stall cycles) when RV32_ARB_PERF_EN is defined.
module rv32_mem_arbiter
  import rv32_types::*;
#(
  parameter int MAX_DATA_BURST = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  memory_request_t  instr_request,
  output memory_response_t instr_response,
  input  memory_request_t  data_request,
  output memory_response_t data_response,
  output memory_request_t  mem_request,
  input  memory_response_t mem_response,
  output logic             grant_data
`ifdef RV32_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_conflict_cycles,
  output logic [CNT_W-1:0] perf_data_stall_cycles
`endif
);

  localparam logic [ARB_STARVE_W-1:0] BURST_LIMIT = ARB_STARVE_W'(MAX_DATA_BURST);

  arb_state_t              state;
  logic [ARB_STARVE_W-1:0] starve_cnt;
  logic                    sel_i, sel_d;
  logic                    fwd_i, fwd_d;
  logic                    done;

  rv32_arb_select #(.MAX_DATA_BURST(MAX_DATA_BURST)) u_select (
    .valid_i    (instr_request.valid),
    .valid_d    (data_request.valid),
    .starve_cnt (starve_cnt),
    .grant_i    (sel_i),
    .grant_d    (sel_d)
  );

  // Reset gates every output so nothing leaks to memory while reset is held.
  always_comb begin
    fwd_i = 1'b0;
    fwd_d = 1'b0;
    if (!reset) begin
      case (state)
        ARB_IDLE:   begin fwd_i = sel_i; fwd_d = sel_d; end
        ARB_LOCK_I: fwd_i = 1'b1;
        ARB_LOCK_D: fwd_d = 1'b1;
        default:    ;
      endcase
    end

    mem_request    = '0;
    instr_response = '0;
    data_response  = '0;
    if (fwd_d) begin
      mem_request         = data_request;
      data_response.ready = mem_response.ready && data_request.valid;
      data_response.data  = mem_response.data;
    end else if (fwd_i) begin
      mem_request          = instr_request;
      instr_response.ready = mem_response.ready && instr_request.valid;
      instr_response.data  = mem_response.data;
    end

    done       = mem_request.valid && mem_response.ready;
    grant_data = fwd_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else if (done) begin
      state <= ARB_IDLE;
      if (fwd_d && instr_request.valid)
        starve_cnt <= (starve_cnt == BURST_LIMIT) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
    end else if (!mem_request.valid) begin
      // Nothing to forward, or the locked requester withdrew: release the port.
      state <= ARB_IDLE;
    end else if (fwd_d) begin
      state <= ARB_LOCK_D;
    end else begin
      state <= ARB_LOCK_I;
    end
  end

`ifdef RV32_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict_cycles   <= '0;
      perf_data_stall_cycles <= '0;
    end else begin
      if (instr_request.valid && data_request.valid)
        perf_conflict_cycles <= perf_conflict_cycles + 1'b1;
      if (data_request.valid && !data_response.ready)
        perf_data_stall_cycles <= perf_data_stall_cycles + 1'b1;
    end
  end
`endif

endmodule
